// File: rtl/axis_ddr_rd_checker_pkg.sv
// Shared types and helpers for the DDR read-data checker: FSM encoding,
// lane width and the incrementing-pattern lane function.
package axis_ddr_rd_checker_pkg;

  localparam int LANE_W = 32;

  // One-hot FSM encoding
  typedef enum logic [4:0] {
    INIT_ST  = 5'b00001,
    IDLE_ST  = 5'b00010,
    LATCH_ST = 5'b00100,
    RUN_ST   = 5'b01000,
    DONE_ST  = 5'b10000
  } state_t;

  // Lane j of beat k: seed + k*lanes + j, wrapping mod 2^32
  function automatic logic [LANE_W-1:0] exp_lane(input logic [31:0] seed,
                                                  input logic [31:0] k,
                                                  input int unsigned j,
                                                  input int unsigned lanes);
    logic [31:0] l32;
    logic [31:0] j32;
    l32 = lanes[31:0];
    j32 = j[31:0];
    return seed + k * l32 + j32;
  endfunction

endpackage

// File: rtl/axis_chk_pattern_gen.sv
// Running expected-beat generator: base is loaded with the seed and steps by
// the lane count on each accepted beat, so no multiplier sits in the compare path.
module axis_chk_pattern_gen
  import axis_ddr_rd_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic [31:0]           seed,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] exp_data
);

  localparam int LANES = DATA_WIDTH / LANE_W;

  logic [31:0] base;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      base <= '0;
    end else if (load) begin
      base <= seed;
    end else if (advance) begin
      base <= base + 32'(LANES);
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign exp_data[j*LANE_W +: LANE_W] = exp_lane(base, 32'd0, j, LANES);
  end

endmodule

// File: rtl/axis_ddr_rd_checker.sv
// AXIS sink that checks DDR read data against a seeded incrementing pattern
// and counts beats, errors and active cycles. AXIS_DDR_RD_CHECKER_BP_EN adds
// LFSR-driven backpressure on tready.
module axis_ddr_rd_checker
  import axis_ddr_rd_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  input  logic                    START_REG,
  input  logic [31:0]             LENGTH_REG,
  input  logic [31:0]             SEED_REG,
  output logic                    IDLE_REG,
  output logic                    DONE_REG,
  output logic [CNT_WIDTH-1:0]    BEATS_REG,
  output logic [CNT_WIDTH-1:0]    ERR_CNT_REG,
  output logic [31:0]             FIRST_ERR_IDX_REG,
  output logic [CNT_WIDTH-1:0]    CYCLES_REG,
  output state_t                  fsm_state
);

  // Handshake: a beat is accepted on a rising edge where tvalid & tready are
  // both high; tready depends only on registered state, never on tvalid.

  state_t                 state, state_nx;
  logic [31:0]            len_q;
  logic [CNT_WIDTH-1:0]   beats_q, err_q, cycles_q;
  logic [31:0]            first_q;
  logic [DATA_WIDTH-1:0]  exp_data;
  logic                   bp_ok, hs, mismatch, last_beat;
  logic [31:0]            beat_idx;
  logic                   unused_in;

  assign unused_in = ^{s_axis_tstrb, s_axis_tlast};

`ifdef AXIS_DDR_RD_CHECKER_BP_EN
  logic [15:0] lfsr;

  // Galois form of x^16+x^14+x^13+x^11+1
  always_ff @(posedge clk) begin
    if (!rstn) lfsr <= 16'hACE1;
    else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign bp_ok = (lfsr[1:0] != 2'b00);
`else
  assign bp_ok = 1'b1;
`endif

  assign s_axis_tready = (state == RUN_ST) && bp_ok;
  assign hs            = s_axis_tvalid && s_axis_tready;
  assign mismatch      = (s_axis_tdata != exp_data);
  assign beat_idx      = 32'(beats_q);
  assign last_beat     = (beat_idx == len_q - 32'd1);

  axis_chk_pattern_gen #(.DATA_WIDTH(DATA_WIDTH)) u_pattern (
    .clk      (clk),
    .rstn     (rstn),
    .load     (state == LATCH_ST),
    .seed     (SEED_REG),
    .advance  (hs),
    .exp_data (exp_data)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= INIT_ST;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      INIT_ST:  state_nx = IDLE_ST;
      IDLE_ST:  if (START_REG) state_nx = LATCH_ST;
      LATCH_ST: state_nx = (LENGTH_REG == 32'd0) ? DONE_ST : RUN_ST;
      RUN_ST:   if (hs && last_beat) state_nx = DONE_ST;
      DONE_ST:  if (!START_REG) state_nx = IDLE_ST;
      default:  state_nx = INIT_ST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      len_q    <= '0;
      beats_q  <= '0;
      err_q    <= '0;
      cycles_q <= '0;
      first_q  <= '1;
    end else if (state == LATCH_ST) begin
      len_q    <= LENGTH_REG;
      beats_q  <= '0;
      err_q    <= '0;
      cycles_q <= '0;
      first_q  <= '1;
    end else if (state == RUN_ST) begin
      // Cycle count opens on the first handshake and runs through stalls
      if (hs || beats_q != '0) cycles_q <= cycles_q + CNT_WIDTH'(1);
      if (hs) begin
        beats_q <= beats_q + CNT_WIDTH'(1);
        if (mismatch) begin
          if (err_q != '1) err_q <= err_q + CNT_WIDTH'(1);
          if (err_q == '0) first_q <= beat_idx;
        end
      end
    end
  end

  assign IDLE_REG          = (state == IDLE_ST);
  assign DONE_REG          = (state == DONE_ST);
  assign BEATS_REG         = beats_q;
  assign ERR_CNT_REG       = err_q;
  assign FIRST_ERR_IDX_REG = first_q;
  assign CYCLES_REG        = cycles_q;
  assign fsm_state         = state;

endmodule

// File: tb/tb_axis_ddr_rd_checker.sv
// Directed bench for axis_ddr_rd_checker: a driver issues runs and pushes the
// hand-computed final status; a monitor pops and compares on each DONE rise.
module tb_axis_ddr_rd_checker;
  import axis_ddr_rd_checker_pkg::*;

  localparam int DW = 64;
  localparam int CW = 32;
  localparam int RW = 129;
`ifdef AXIS_DDR_RD_CHECKER_BP_EN
  localparam bit EXACT_CYC = 1'b0;
`else
  localparam bit EXACT_CYC = 1'b1;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic            s_axis_tvalid;
  logic [DW-1:0]   s_axis_tdata;
  logic [DW/8-1:0] s_axis_tstrb;
  logic            s_axis_tlast;
  logic            s_axis_tready;
  logic            START_REG;
  logic [31:0]     LENGTH_REG, SEED_REG;
  logic            IDLE_REG, DONE_REG;
  logic [CW-1:0]   BEATS_REG, ERR_CNT_REG, CYCLES_REG;
  logic [31:0]     FIRST_ERR_IDX_REG;
  state_t          fsm_state;

  axis_ddr_rd_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tstrb      (s_axis_tstrb),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tready     (s_axis_tready),
    .START_REG         (START_REG),
    .LENGTH_REG        (LENGTH_REG),
    .SEED_REG          (SEED_REG),
    .IDLE_REG          (IDLE_REG),
    .DONE_REG          (DONE_REG),
    .BEATS_REG         (BEATS_REG),
    .ERR_CNT_REG       (ERR_CNT_REG),
    .FIRST_ERR_IDX_REG (FIRST_ERR_IDX_REG),
    .CYCLES_REG        (CYCLES_REG),
    .fsm_state         (fsm_state)
  );

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // scoreboard monitor: one expected record per run reaching DONE
  logic          done_d = 1'b0;
  logic [RW-1:0] mon_e;
  always @(negedge clk) begin
    if (rstn === 1'b1 && DONE_REG === 1'b1 && !done_d) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: no expected record queued");
      end else begin
        mon_e = exp_q.pop_front();
        chk("beats", 64'(BEATS_REG), 64'(mon_e[127:96]));
        chk("err_cnt", 64'(ERR_CNT_REG), 64'(mon_e[95:64]));
        chk("first_err_idx", 64'(FIRST_ERR_IDX_REG), 64'(mon_e[63:32]));
        if (mon_e[128]) chk("cycles", 64'(CYCLES_REG), 64'(mon_e[31:0]));
      end
    end
    done_d = DONE_REG;
  end

  // backpressure statistics over RUN cycles
  bit bp_mon = 1'b0;
  int run_cyc = 0;
  int low_cyc = 0;
  always @(negedge clk) begin
    if (bp_mon && fsm_state == RUN_ST) begin
      run_cyc++;
      if (!s_axis_tready) low_cyc++;
    end
  end

  function automatic logic [DW-1:0] beat_data(input logic [31:0] seed, input int k);
    logic [31:0] lo;
    logic [31:0] hi;
    lo = seed + 32'(2 * k);
    hi = lo + 32'd1;
    return {hi, lo};
  endfunction

  task automatic push_exp(input bit chk_cyc, input logic [31:0] beats, input logic [31:0] err,
                          input logic [31:0] first, input logic [31:0] cyc);
    exp_q.push_back({chk_cyc, beats, err, first, cyc});
  endtask

  // drives len beats; handshake decided at negedge where tready is stable
  task automatic drive_beats(input logic [31:0] seed, input int len, input bit alt,
                             input int c0k, input logic [DW-1:0] c0m,
                             input int c1k, input logic [DW-1:0] c1m);
    int k = 0;
    int budget = 0;
    bit ph = 1'b0;
    bit hs;
    while (k < len && budget < 3000) begin
      @(negedge clk);
      budget++;
      ph = !ph;
      s_axis_tvalid = alt ? ph : 1'b1;
      s_axis_tdata  = beat_data(seed, k) ^ ((k == c0k) ? c0m : '0) ^ ((k == c1k) ? c1m : '0);
      hs = s_axis_tvalid && s_axis_tready;
      @(posedge clk);
      if (hs) k++;
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    if (k < len) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: accepted %0d beats, expected %0d", k, len);
    end
  endtask

  task automatic finish_run(input string tag);
    int n = 0;
    while (DONE_REG !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 64'(DONE_REG), 64'd1);
    chk({tag, "_tready_in_done"}, 64'(s_axis_tready), 64'd0);
    repeat (2) @(negedge clk);
    chk({tag, "_done_hold"}, 64'(DONE_REG), 64'd1);
    START_REG = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_after_start_low"}, 64'(IDLE_REG), 64'd1);
  endtask

  task automatic start_run(input logic [31:0] seed, input logic [31:0] len);
    @(negedge clk);
    SEED_REG   = seed;
    LENGTH_REG = len;
    START_REG  = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    rstn = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '1;
    s_axis_tlast  = 1'b0;
    START_REG  = 1'b0;
    LENGTH_REG = '0;
    SEED_REG   = '0;
    repeat (3) @(negedge clk);

    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_idle", 64'(IDLE_REG), 64'd0);
    chk("rst_done", 64'(DONE_REG), 64'd0);
    chk("rst_beats", 64'(BEATS_REG), 64'd0);
    chk("rst_err", 64'(ERR_CNT_REG), 64'd0);
    chk("rst_cycles", 64'(CYCLES_REG), 64'd0);
    chk("rst_first", 64'(FIRST_ERR_IDX_REG), 64'hFFFF_FFFF);
    chk("rst_state", 64'(fsm_state), 64'(INIT_ST));
    rstn = 1'b1;
    @(negedge clk);
    chk("idle_after_init", 64'(IDLE_REG), 64'd1);

    // clean run, tvalid held high
    push_exp(EXACT_CYC, 32'd16, 32'd0, 32'hFFFF_FFFF, 32'd16);
    start_run(32'h1000, 32'd16);
    drive_beats(32'h1000, 16, 1'b0, -1, '0, -1, '0);
    finish_run("clean");

    // beat 5 lane 1 bit 0 flipped, beat 9 lane 0 corrupted
    push_exp(EXACT_CYC, 32'd16, 32'd2, 32'd5, 32'd16);
    start_run(32'h1000, 32'd16);
    drive_beats(32'h1000, 16, 1'b0, 5, 64'h0000_0001_0000_0000, 9, 64'h0000_0000_0000_00FF);
    finish_run("corrupt");

    // tvalid on alternate cycles
    push_exp(EXACT_CYC, 32'd16, 32'd0, 32'hFFFF_FFFF, 32'd31);
    start_run(32'h1000, 32'd16);
    drive_beats(32'h1000, 16, 1'b1, -1, '0, -1, '0);
    finish_run("alt");

    // zero length
    push_exp(1'b1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0);
    start_run(32'h55, 32'd0);
    n = 0;
    seen = 1'b0;
    while (DONE_REG !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
      seen |= s_axis_tready;
    end
    chk("len0_latency", 64'(n), 64'd2);
    chk("len0_tready_seen", 64'(seen), 64'd0);
    finish_run("len0");

    // seed wrap-around
    push_exp(EXACT_CYC, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd2);
    start_run(32'hFFFF_FFFE, 32'd2);
    chk("wrap_vec0", beat_data(32'hFFFF_FFFE, 0), 64'hFFFF_FFFF_FFFF_FFFE);
    chk("wrap_vec1", beat_data(32'hFFFF_FFFE, 1), 64'h0000_0001_0000_0000);
    drive_beats(32'hFFFF_FFFE, 2, 1'b0, -1, '0, -1, '0);
    finish_run("wrap");

    // reset mid-run with START held; only the relaunched run completes
    push_exp(EXACT_CYC, 32'd16, 32'd0, 32'hFFFF_FFFF, 32'd16);
    start_run(32'h2000, 32'd16);
    drive_beats(32'h2000, 7, 1'b0, -1, '0, -1, '0);
    chk("pre_rst_beats", 64'(BEATS_REG), 64'd7);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_beats", 64'(BEATS_REG), 64'd0);
    chk("midrst_first", 64'(FIRST_ERR_IDX_REG), 64'hFFFF_FFFF);
    chk("midrst_tready", 64'(s_axis_tready), 64'd0);
    chk("midrst_state", 64'(fsm_state), 64'(INIT_ST));
    rstn = 1'b1;
    drive_beats(32'h2000, 16, 1'b0, -1, '0, -1, '0);
    finish_run("relaunch");

    // long run; backpressure when the feature is built in
    push_exp(EXACT_CYC, 32'd64, 32'd0, 32'hFFFF_FFFF, 32'd64);
    run_cyc = 0;
    low_cyc = 0;
    bp_mon  = 1'b1;
    start_run(32'h3000, 32'd64);
    drive_beats(32'h3000, 64, 1'b0, -1, '0, -1, '0);
    finish_run("long");
    bp_mon = 1'b0;
`ifdef AXIS_DDR_RD_CHECKER_BP_EN
    chk("bp_cycles_gt_len", 64'(CYCLES_REG > 64), 64'd1);
    chk("bp_low_share", 64'((low_cyc * 8 >= run_cyc) && (low_cyc * 2 <= run_cyc)), 64'd1);
`else
    chk("nobp_low_cycles", 64'(low_cyc), 64'd0);
    chk("nobp_run_cycles", 64'(run_cyc), 64'd64);
`endif

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_ddr_rd_checker.md
Name: axis_ddr_rd_checker

Overview:
- AXIS sink directly downstream of the DDR burst-read master in the DDR bandwidth test.
- Consumes the read-data stream and checks every beat against a deterministic incrementing pattern seeded by software.
- Counts beats, errors and active cycles so software can compute read bandwidth and data integrity.
- Uses the same START/IDLE register handshake as the read master so both can be launched from one register write.

Parameters:
- DATA_WIDTH, 64: stream width in bits; must be a multiple of 32.
- CNT_WIDTH, 32: width of the beat, error and cycle counters.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- s_axis_tvalid  in  1  upstream data valid.
- s_axis_tdata  in  DATA_WIDTH  read data.
- s_axis_tstrb  in  DATA_WIDTH/8  ignored; upstream drives all-ones.
- s_axis_tlast  in  1  ignored; end of transfer is determined by LENGTH_REG.
- s_axis_tready  out  1  sink ready.
- START_REG  in  1  level-sensitive run request.
- LENGTH_REG  in  32  number of beats expected.
- SEED_REG  in  32  pattern seed.
- IDLE_REG  out  1  high in IDLE_ST.
- DONE_REG  out  1  high in DONE_ST.
- BEATS_REG  out  CNT_WIDTH  beats accepted.
- ERR_CNT_REG  out  CNT_WIDTH  mismatching beats; saturates at all-ones.
- FIRST_ERR_IDX_REG  out  32  index of the first bad beat; all-ones if no error.
- CYCLES_REG  out  CNT_WIDTH  cycles from the first handshake to the last handshake, inclusive.

Behaviour:
- Reset values:
  - state = INIT_ST.
  - s_axis_tready = 0, IDLE_REG = 0, DONE_REG = 0.
  - BEATS_REG = 0, ERR_CNT_REG = 0, CYCLES_REG = 0.
  - FIRST_ERR_IDX_REG = 0xFFFFFFFF.
- Expected pattern: for beat k, 32-bit lane j = SEED + k*(DATA_WIDTH/32) + j, computed mod 2^32 so it wraps naturally.
  - Mismatch = any bit of any lane differs.
- State machine (one-hot):
  - INIT_ST -> IDLE_ST unconditionally.
  - IDLE_ST: IDLE_REG = 1. Moves to LATCH_ST when START_REG == 1.
  - LATCH_ST: captures LENGTH_REG and SEED_REG, and clears the beat, error and cycle counters plus FIRST_ERR_IDX. Moves to DONE_ST if the captured length is 0, otherwise to RUN_ST.
  - RUN_ST: s_axis_tready = 1. Each handshake (tvalid & tready) compares the beat, increments BEATS and, on a mismatch, increments ERR_CNT.
    - FIRST_ERR_IDX is loaded with the current beat index on the first mismatch only.
    - Moves to DONE_ST in the cycle after the handshake of beat LENGTH-1. tready is 0 in DONE_ST, so no extra beat is ever accepted.
  - DONE_ST: DONE_REG = 1 and all counters hold. Moves to IDLE_ST when START_REG == 0.
- Cycle counter:
  - Starts on the first handshake cycle, which counts as 1.
  - Increments every cycle in RUN_ST thereafter, including stall cycles.
  - Stops after the last handshake. With no stalls, CYCLES = LENGTH.
- Timing:
  - All status outputs are registered and update on the same edge that samples the handshake.
  - tready is decoded from the state register only, never from tvalid.
- Output stability: while not in DONE_ST, outputs show live values. Software should read them only once DONE_REG = 1.
- Reset during RUN_ST: returns everything to reset values. If START_REG is still high, a new run launches via INIT -> IDLE -> LATCH. Beats still buffered upstream are then checked as a new run.
- START_REG dropping during RUN_ST is ignored; the run completes.
- LENGTH_REG and SEED_REG changes after LATCH_ST have no effect on the current run.

Optional Feature:
- Macro: AXIS_DDR_RD_CHECKER_BP_EN.
- When defined:
  - A 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, reset value 0xACE1) advances every cycle.
  - In RUN_ST, tready = (lfsr[1:0] != 2'b00), giving roughly 25% backpressure to exercise the read master's fifo-full path.
  - Cycle counting is unchanged.
- When undefined: no LFSR is built and tready = 1 throughout RUN_ST.

Decomposition:
- Package axis_ddr_rd_checker_pkg:
  - state_t enum (INIT_ST, IDLE_ST, LATCH_ST, RUN_ST, DONE_ST).
  - LANE_W = 32.
  - Function exp_lane(seed, k, j, lanes).
- Sub-module axis_chk_pattern_gen: holds the running expected base (base += DATA_WIDTH/32 per handshake, loaded with the seed in LATCH_ST) and outputs the full expected beat. This keeps the multiply out of the compare path.

Test Plan (DATA_WIDTH = 64, macro undefined unless stated):
- SEED = 0x1000, LENGTH = 16, correct data (0x1000..0x101F), tvalid held high -> DONE; BEATS = 16, ERR = 0, FIRST_ERR = 0xFFFFFFFF, CYCLES = 16, tready = 0 after beat 15.
- Same run, but lane 1 of beat 5 XOR 0x1 and lane 0 of beat 9 corrupted -> ERR = 2, FIRST_ERR = 5, BEATS = 16.
- tvalid on alternate cycles, LENGTH = 16 -> CYCLES = 31; DONE holds until START_REG = 0, then IDLE_REG = 1 next cycle.
- LENGTH = 0 -> DONE two cycles after START is seen, tready never asserted, all counters 0.
- SEED = 0xFFFFFFFE, LENGTH = 2, beats {0xFFFFFFFF_FFFFFFFE, 0x00000001_00000000} -> ERR = 0 (wrap-around).
- rstn pulsed after 7 beats with START held -> counters reset, new run latched, 16 fresh beats -> BEATS = 16, ERR = 0. Then rebuild with AXIS_DDR_RD_CHECKER_BP_EN and 64 beats -> ERR = 0, CYCLES > 64, tready low in ~25% of RUN cycles.
